// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
// Imported by rr_arb2 and dmem_arbiter.
package dmem_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_sel_t;

  localparam logic [3:0] XFER_DW = 4'b1000;
  localparam int LAT_MAX = 7;
  localparam int CNT_W = 3;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: on a contest the port that did
// not win last time gets the grant.
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  port_sel_t  last,
  output port_sel_t  sel
);

  always_comb begin
    sel = PORT_A;
    unique case (1'b1)
      (req == 2'b11): sel = (last == PORT_A) ? PORT_B : PORT_A;
      (req == 2'b10): sel = PORT_B;
      default:        sel = PORT_A;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port datamem arbiter, one access outstanding, fixed read latency.
// Optional per-port wait counters with DMEM_ARB_PERF_EN.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int LAT    = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  input  logic [3:0]        a_size,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  input  logic [3:0]        b_size,
  output logic              a_gnt,
  output logic              b_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  output logic [3:0]        m_size,
  output logic              m_we,
  output logic              m_re,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              busy
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [31:0]       a_wait_cnt,
  output logic [31:0]       b_wait_cnt
`endif
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  port_sel_t        last_q, last_d;
  port_sel_t        owner_q, owner_d;
  port_sel_t        sel;

  logic gnt;
  logic g_we;
  logic done;

  rr_arb2 u_rr (
    .req  ({b_req, a_req}),
    .last (last_q),
    .sel  (sel)
  );

  // Gating with reset keeps every output quiet while reset is held
  assign gnt  = reset && (state_q == IDLE) && (a_req || b_req);
  assign g_we = (sel == PORT_B) ? b_we : a_we;
  assign done = reset && (state_q == WAIT) && (cnt_q == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= PORT_B;
      owner_q <= PORT_A;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      owner_q <= owner_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    owner_d = owner_q;
    unique case (state_q)
      IDLE: begin
        if (gnt) begin
          last_d = sel;
          if (!g_we) begin
            state_d = WAIT;
            cnt_d   = CNT_W'(LAT - 1);
            owner_d = sel;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    a_gnt    = 1'b0;
    b_gnt    = 1'b0;
    a_rvalid = 1'b0;
    b_rvalid = 1'b0;
    a_rdata  = '0;
    b_rdata  = '0;
    m_addr   = '0;
    m_wdata  = '0;
    m_size   = '0;
    m_we     = 1'b0;
    m_re     = 1'b0;
    busy     = (state_q == WAIT);
    if (gnt) begin
      a_gnt   = (sel == PORT_A);
      b_gnt   = (sel == PORT_B);
      m_addr  = (sel == PORT_B) ? b_addr  : a_addr;
      m_wdata = (sel == PORT_B) ? b_wdata : a_wdata;
      m_size  = (sel == PORT_B) ? b_size  : a_size;
      m_we    = g_we;
      m_re    = !g_we;
    end
    if (done) begin
      a_rvalid = (owner_q == PORT_A);
      b_rvalid = (owner_q == PORT_B);
      a_rdata  = (owner_q == PORT_A) ? m_rdata : '0;
      b_rdata  = (owner_q == PORT_B) ? m_rdata : '0;
    end
  end

`ifdef DMEM_ARB_PERF_EN
  logic [31:0] a_wait_q, b_wait_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_wait_q <= '0;
      b_wait_q <= '0;
    end else begin
      if (a_req && !a_gnt && (a_wait_q != '1)) a_wait_q <= a_wait_q + 1'b1;
      if (b_req && !b_gnt && (b_wait_q != '1)) b_wait_q <= b_wait_q + 1'b1;
    end
  end

  assign a_wait_cnt = a_wait_q;
  assign b_wait_cnt = b_wait_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: three instances (LAT=1,2,3)
// share stimulus; each scenario checks the instance it targets.
module tb_dmem_arbiter;

  logic clk;
  logic reset;
  logic a_req, a_we, b_req, b_we;
  logic [63:0] a_addr, a_wdata, b_addr, b_wdata;
  logic [3:0] a_size, b_size;
  logic [63:0] m_rdata;

  logic [2:0] a_gnt, b_gnt, a_rvalid, b_rvalid;
  logic [2:0] m_we, m_re, busy;
  logic [63:0] a_rdata [3];
  logic [63:0] b_rdata [3];
  logic [63:0] m_addr [3];
  logic [63:0] m_wdata [3];
  logic [3:0] m_size [3];
`ifdef DMEM_ARB_PERF_EN
  logic [31:0] a_wait_cnt [3];
  logic [31:0] b_wait_cnt [3];
`endif

  int checks = 0;
  int failures = 0;
  int cur = 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dmem_arbiter #(
      .ADDR_W (64),
      .DATA_W (64),
      .LAT    (g + 1)
    ) u_dut (
      .clk      (clk),
      .reset    (reset),
      .a_req    (a_req),
      .a_we     (a_we),
      .a_addr   (a_addr),
      .a_wdata  (a_wdata),
      .a_size   (a_size),
      .b_req    (b_req),
      .b_we     (b_we),
      .b_addr   (b_addr),
      .b_wdata  (b_wdata),
      .b_size   (b_size),
      .a_gnt    (a_gnt[g]),
      .b_gnt    (b_gnt[g]),
      .a_rvalid (a_rvalid[g]),
      .a_rdata  (a_rdata[g]),
      .b_rvalid (b_rvalid[g]),
      .b_rdata  (b_rdata[g]),
      .m_addr   (m_addr[g]),
      .m_wdata  (m_wdata[g]),
      .m_size   (m_size[g]),
      .m_we     (m_we[g]),
      .m_re     (m_re[g]),
      .m_rdata  (m_rdata),
      .busy     (busy[g])
`ifdef DMEM_ARB_PERF_EN
      ,
      .a_wait_cnt (a_wait_cnt[g]),
      .b_wait_cnt (b_wait_cnt[g])
`endif
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Requesters must hold req until granted
  logic pend_a = 1'b0;
  logic pend_b = 1'b0;
  always @(posedge clk) begin
    if (!reset) begin
      pend_a = 1'b0;
      pend_b = 1'b0;
    end else begin
      if (pend_a) begin
        checks++;
        assert (a_req === 1'b1) else begin
          failures++;
          $error("FAIL proto_a_hold observed=%0b expected=1", a_req);
        end
      end
      if (pend_b) begin
        checks++;
        assert (b_req === 1'b1) else begin
          failures++;
          $error("FAIL proto_b_hold observed=%0b expected=1", b_req);
        end
      end
      pend_a = a_req && !a_gnt[cur];
      pend_b = b_req && !b_gnt[cur];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0; a_size = 0;
    b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0; b_size = 0;
    m_rdata = 0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle_in();
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    idle_in();
    a_req = 1; a_addr = 64'h55; a_size = 4'b1000;
    #2;
    chk("rst_a_gnt", a_gnt[1], 0);
    chk("rst_m_re", m_re[1], 0);
    chk("rst_m_addr", m_addr[1], 0);
    chk("rst_busy", busy[1], 0);
    tick();
    chk("rst_edge_a_gnt", a_gnt[1], 0);
    chk("rst_edge_m_size", m_size[1], 0);

    // Single A read, LAT=2
    cur = 1;
    do_reset();
    a_req = 1; a_we = 0; a_addr = 64'h10; a_size = 4'b1000;
    #1;
    chk("s1_c0_a_gnt", a_gnt[1], 1);
    chk("s1_c0_b_gnt", b_gnt[1], 0);
    chk("s1_c0_m_re", m_re[1], 1);
    chk("s1_c0_m_we", m_we[1], 0);
    chk("s1_c0_m_addr", m_addr[1], 64'h10);
    chk("s1_c0_m_size", m_size[1], 4'b1000);
    chk("s1_c0_busy", busy[1], 0);
    tick();
    a_req = 0; a_addr = 0; a_size = 0;
    #1;
    chk("s1_c1_busy", busy[1], 1);
    chk("s1_c1_a_rvalid", a_rvalid[1], 0);
    chk("s1_c1_m_re", m_re[1], 0);
    tick();
    m_rdata = 64'hDEAD;
    #1;
    chk("s1_c2_a_rvalid", a_rvalid[1], 1);
    chk("s1_c2_a_rdata", a_rdata[1], 64'hDEAD);
    chk("s1_c2_b_rvalid", b_rvalid[1], 0);
    chk("s1_c2_b_rdata", b_rdata[1], 0);
    tick();
    #1;
    chk("s1_c3_a_rvalid", a_rvalid[1], 0);
    chk("s1_c3_a_rdata", a_rdata[1], 0);
    chk("s1_c3_busy", busy[1], 0);
    chk("s1_c3_m_addr", m_addr[1], 0);

    // A and B read together, A first, B at cycle 3
    do_reset();
    a_req = 1; a_addr = 64'h20; a_size = 4'b1000;
    b_req = 1; b_addr = 64'h40; b_size = 4'b0100;
    #1;
    chk("s2_c0_a_gnt", a_gnt[1], 1);
    chk("s2_c0_b_gnt", b_gnt[1], 0);
    chk("s2_c0_m_addr", m_addr[1], 64'h20);
    tick();
    a_req = 0;
    #1;
    chk("s2_c1_b_gnt", b_gnt[1], 0);
    tick();
    m_rdata = 64'h1234;
    #1;
    chk("s2_c2_a_rvalid", a_rvalid[1], 1);
    chk("s2_c2_b_gnt", b_gnt[1], 0);
    tick();
    #1;
    chk("s2_c3_b_gnt", b_gnt[1], 1);
    chk("s2_c3_m_addr", m_addr[1], 64'h40);
    chk("s2_c3_m_size", m_size[1], 4'b0100);
    tick();
    b_req = 0;
    #1;
    chk("s2_c4_b_rvalid", b_rvalid[1], 0);
    tick();
    m_rdata = 64'hBEEF;
    #1;
    chk("s2_c5_b_rvalid", b_rvalid[1], 1);
    chk("s2_c5_b_rdata", b_rdata[1], 64'hBEEF);
    chk("s2_c5_a_rvalid", a_rvalid[1], 0);

    // Back-to-back A writes, then a write contest
    do_reset();
    for (int i = 0; i < 4; i++) begin
      a_req = 1; a_we = 1; a_addr = 64'(i * 8);
      a_wdata = 64'h100 + 64'(i); a_size = 4'b1000;
      #1;
      chk("s3_a_gnt", a_gnt[1], 1);
      chk("s3_m_we", m_we[1], 1);
      chk("s3_m_re", m_re[1], 0);
      chk("s3_m_addr", m_addr[1], 64'(i * 8));
      chk("s3_m_wdata", m_wdata[1], 64'h100 + 64'(i));
      chk("s3_busy", busy[1], 0);
      tick();
    end
    a_req = 0; a_we = 0;
    #1;
    chk("s3_idle_a_gnt", a_gnt[1], 0);
    chk("s3_idle_m_we", m_we[1], 0);
    chk("s3_idle_m_wdata", m_wdata[1], 0);
    a_req = 1; a_we = 1; a_addr = 64'h200;
    b_req = 1; b_we = 1; b_addr = 64'h300; b_wdata = 64'h77;
    #1;
    chk("s3_rr_b_gnt", b_gnt[1], 1);
    chk("s3_rr_a_gnt", a_gnt[1], 0);
    chk("s3_rr_m_wdata", m_wdata[1], 64'h77);
    tick();
    b_req = 0; b_we = 0;
    #1;
    chk("s3_rr2_a_gnt", a_gnt[1], 1);
    chk("s3_rr2_m_addr", m_addr[1], 64'h200);
    tick();
    a_req = 0; a_we = 0;

    // B read dropped by reset during WAIT
    do_reset();
    b_req = 1; b_addr = 64'h80; b_size = 4'b1000;
    #1;
    chk("s4_c0_b_gnt", b_gnt[1], 1);
    chk("s4_c0_m_re", m_re[1], 1);
    tick();
    b_req = 0;
    reset = 0;
    a_req = 1; a_addr = 64'h30; a_size = 4'b1000;
    #1;
    chk("s4_c1_a_gnt", a_gnt[1], 0);
    chk("s4_c1_m_re", m_re[1], 0);
    chk("s4_c1_m_addr", m_addr[1], 0);
    chk("s4_c1_busy", busy[1], 0);
    chk("s4_c1_b_rvalid", b_rvalid[1], 0);
    tick();
    #1;
    chk("s4_c2_b_rvalid", b_rvalid[1], 0);
    chk("s4_c2_a_gnt", a_gnt[1], 0);
    tick();
    reset = 1;
    b_req = 1; b_addr = 64'h90;
    #1;
    chk("s4_c3_a_gnt", a_gnt[1], 1);
    chk("s4_c3_b_gnt", b_gnt[1], 0);
    chk("s4_c3_b_rvalid", b_rvalid[1], 0);
    tick();
    a_req = 0;
    #1;
    chk("s4_c4_b_rvalid", b_rvalid[1], 0);
    chk("s4_c4_busy", busy[1], 1);

    // LAT=3: B waits behind an A read
    cur = 2;
    do_reset();
    a_req = 1; a_addr = 64'h18; a_size = 4'b1000;
    b_req = 1; b_addr = 64'h28; b_size = 4'b1000;
    #1;
    chk("s5_c0_a_gnt", a_gnt[2], 1);
    tick();
    a_req = 0;
    for (int c = 1; c < 4; c++) begin
      if (c == 3) m_rdata = 64'hCAFE;
      #1;
      chk("s5_wait_b_gnt", b_gnt[2], 0);
      chk("s5_wait_busy", busy[2], 1);
      chk("s5_wait_a_rvalid", a_rvalid[2], (c == 3) ? 1 : 0);
      tick();
    end
    #1;
    chk("s5_c4_b_gnt", b_gnt[2], 1);
    chk("s5_c4_m_addr", m_addr[2], 64'h28);
`ifdef DMEM_ARB_PERF_EN
    chk("s5_b_wait_cnt", b_wait_cnt[2], 4);
    chk("s5_a_wait_cnt", a_wait_cnt[2], 0);
`endif
    tick();
    b_req = 0;

    // LAT=1: rvalid next cycle, next grant two cycles after
    cur = 0;
    do_reset();
    a_req = 1; a_addr = 64'h8; a_size = 4'b1000;
    b_req = 1; b_addr = 64'h48; b_size = 4'b1000;
    #1;
    chk("s6_c0_a_gnt", a_gnt[0], 1);
    tick();
    a_req = 0;
    m_rdata = 64'h5A5A;
    #1;
    chk("s6_c1_a_rvalid", a_rvalid[0], 1);
    chk("s6_c1_a_rdata", a_rdata[0], 64'h5A5A);
    chk("s6_c1_b_gnt", b_gnt[0], 0);
    tick();
    #1;
    chk("s6_c2_b_gnt", b_gnt[0], 1);
    chk("s6_c2_a_rvalid", a_rvalid[0], 0);
    tick();
    b_req = 0;
    m_rdata = 64'h6B6B;
    #1;
    chk("s6_c3_b_rvalid", b_rvalid[0], 1);
    chk("s6_c3_b_rdata", b_rdata[0], 64'h6B6B);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
